// File: rtl/bcd_to_binary_serial_pkg.sv
// Shared types and constants for the serial BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } bcd_state_t;

  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
  localparam logic [3:0] BCD_ADJ_THRESH = 4'd8;
  localparam logic [3:0] BCD_ADJ_VALUE  = 4'd3;

endpackage

// File: rtl/bcd_to_binary_serial_if.sv
// Request/result bundle between a BCD source and the serial converter.
interface bcd_to_binary_serial_if #(
  parameter int unsigned DIGITS = 2
);
  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned BIN_W = $clog2(10 ** DIGITS);

  logic             start;
  logic [BCD_W-1:0] bcd_in;
  logic             busy;
  logic             done;
  logic             err;
  logic [BIN_W-1:0] bin_out;

  modport master (
    output start, bcd_in,
    input  busy, done, err, bin_out
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, err, bin_out
  );

endinterface

// File: rtl/bcd_to_binary_serial_digit_adjust.sv
// One reverse double-dabble digit correction: subtract 3 when the field is 8 or more.
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] digit_adj_c
);

  always_comb begin
    digit_adj_c = digit;
    if (digit >= BCD_ADJ_THRESH) begin
      digit_adj_c = digit - BCD_ADJ_VALUE;
    end
  end

endmodule

// File: rtl/bcd_to_binary_serial.sv
// Iterative packed-BCD to unsigned binary converter using reverse double-dabble.
module bcd_to_binary_serial
  import bcd_pkg::*;
#(
  parameter int unsigned DIGITS = 2
) (
  input  logic                    CLOCK_50,
  input  logic                    RESET_N,
  bcd_to_binary_serial_if.slave   bus
);

  localparam int unsigned BCD_W = 4 * DIGITS;
  localparam int unsigned BIN_W = $clog2(10 ** DIGITS);
  localparam int unsigned SR_W  = BCD_W + BIN_W;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  bcd_state_t       state_q, state_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [SR_W-1:0]  sr_shift, sr_adj;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             err_pend_q, err_pend_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic             bcd_bad;

  // Shift right, then correct every BCD field that now reads 8 or more
  assign sr_shift = {1'b0, sr_q[SR_W-1:1]};
  assign sr_adj[BIN_W-1:0] = sr_shift[BIN_W-1:0];

  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .digit       (sr_shift[BIN_W + 4*i +: 4]),
      .digit_adj_c (sr_adj[BIN_W + 4*i +: 4])
    );
  end

  always_comb begin
    bcd_bad = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (bus.bcd_in[4*i +: 4] > BCD_MAX_DIGIT) begin
        bcd_bad = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    err_pend_d = err_pend_q;
    bin_d      = bin_q;

    case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          if (bcd_bad) begin
            // Invalid digits skip the shift phase and report a zero result
            err_pend_d = 1'b1;
            sr_d       = '0;
            state_d    = S_DONE;
          end else begin
            err_pend_d = 1'b0;
            sr_d       = {bus.bcd_in, BIN_W'(0)};
            cnt_d      = '0;
            busy_d     = 1'b1;
            state_d    = S_SHIFT;
          end
        end
      end
      S_SHIFT: begin
        sr_d  = sr_adj;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          busy_d  = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        err_d   = err_pend_q;
        bin_d   = sr_q[BIN_W-1:0];
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q    <= S_IDLE;
      sr_q       <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
      bin_q      <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
      bin_q      <= bin_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;
  assign bus.bin_out = bin_q;

endmodule

// File: tb/tb_bcd_to_binary_serial.sv
// Scoreboard bench for bcd_to_binary_serial: 2-digit and 3-digit instances.
module tb_bcd_to_binary_serial;

  typedef struct {
    int bin;
    int err;
    int cyc;
    int busy;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   busy_run2 = 0;
  int   busy_run3 = 0;

  exp_t q2[$];
  exp_t q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  bcd_to_binary_serial_if #(.DIGITS(2)) bus2 ();
  bcd_to_binary_serial_if #(.DIGITS(3)) bus3 ();

  bcd_to_binary_serial #(.DIGITS(2)) u_dut2 (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (bus2)
  );

  bcd_to_binary_serial #(.DIGITS(3)) u_dut3 (
    .CLOCK_50 (clk),
    .RESET_N  (rst_n),
    .bus      (bus3)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 2-digit instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run2 = 0;
    end else begin
      if (bus2.busy) busy_run2++;
      if (bus2.done) begin
        check("d2_busy_with_done", int'(bus2.busy), 0);
        if (q2.size() == 0) begin
          check("d2_unexpected_done", 1, 0);
        end else begin
          e = q2.pop_front();
          check("d2_bin_out", int'(bus2.bin_out), e.bin);
          check("d2_err", int'(bus2.err), e.err);
          check("d2_done_cycle", cyc, e.cyc);
          check("d2_busy_cycles", busy_run2, e.busy);
        end
        busy_run2 = 0;
      end
    end
  end

  // Monitor for the 3-digit instance
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      busy_run3 = 0;
    end else begin
      if (bus3.busy) busy_run3++;
      if (bus3.done) begin
        check("d3_busy_with_done", int'(bus3.busy), 0);
        if (q3.size() == 0) begin
          check("d3_unexpected_done", 1, 0);
        end else begin
          e = q3.pop_front();
          check("d3_bin_out", int'(bus3.bin_out), e.bin);
          check("d3_err", int'(bus3.err), e.err);
          check("d3_done_cycle", cyc, e.cyc);
          check("d3_busy_cycles", busy_run3, e.busy);
        end
        busy_run3 = 0;
      end
    end
  end

  task automatic drain2();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (q2.size() == 0) return;
    end
    check("d2_done_timeout", q2.size(), 0);
    q2.delete();
  endtask

  task automatic drain3();
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      if (q3.size() == 0) return;
    end
    check("d3_done_timeout", q3.size(), 0);
    q3.delete();
  endtask

  // Issue one request on the 2-digit instance and wait for its result
  task automatic conv2(input logic [7:0] bcd, input int exp_bin, input int exp_err);
    @(negedge clk);
    bus2.bcd_in = bcd;
    bus2.start  = 1'b1;
    @(posedge clk);
    #1;
    bus2.start = 1'b0;
    q2.push_back('{exp_bin, exp_err, cyc + ((exp_err != 0) ? 1 : 8), (exp_err != 0) ? 0 : 7});
    drain2();
  endtask

  task automatic conv3(input logic [11:0] bcd, input int exp_bin, input int exp_err);
    @(negedge clk);
    bus3.bcd_in = bcd;
    bus3.start  = 1'b1;
    @(posedge clk);
    #1;
    bus3.start = 1'b0;
    q3.push_back('{exp_bin, exp_err, cyc + ((exp_err != 0) ? 1 : 11), (exp_err != 0) ? 0 : 10});
    drain3();
  endtask

  initial begin
    int k;
    logic [7:0] v;

    bus2.start  = 1'b0;
    bus2.bcd_in = '0;
    bus3.start  = 1'b0;
    bus3.bcd_in = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", int'(bus2.busy), 0);
    check("rst_done", int'(bus2.done), 0);
    check("rst_err", int'(bus2.err), 0);
    check("rst_bin_out", int'(bus2.bin_out), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic conversions
    conv2(8'h42, 42, 0);
    conv2(8'h99, 99, 0);
    conv2(8'h00, 0, 0);

    // Invalid digits, then recovery
    conv2(8'h3A, 0, 1);
    conv2(8'h10, 10, 0);
    conv2(8'hA0, 0, 1);
    conv2(8'hFF, 0, 1);
    conv2(8'h9F, 0, 1);
    conv2(8'h98, 98, 0);

    // start held high; bcd_in changes mid-conversion
    @(negedge clk);
    bus2.bcd_in = 8'h57;
    bus2.start  = 1'b1;
    @(posedge clk);
    #1;
    k = cyc;
    q2.push_back('{57, 0, k + 8, 7});
    repeat (3) @(negedge clk);
    bus2.bcd_in = 8'h12;
    repeat (7) @(posedge clk);
    #1;
    q2.push_back('{12, 0, k + 17, 7});
    bus2.start = 1'b0;
    drain2();
    drain2();

    // Asynchronous reset during SHIFT aborts without a done pulse
    @(negedge clk);
    bus2.bcd_in = 8'h25;
    bus2.start  = 1'b1;
    @(posedge clk);
    #1;
    bus2.start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("pre_abort_busy", int'(bus2.busy), 1);
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(bus2.busy), 0);
    check("abort_done", int'(bus2.done), 0);
    check("abort_err", int'(bus2.err), 0);
    check("abort_bin_out", int'(bus2.bin_out), 0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    conv2(8'h25, 25, 0);

    // All valid two-digit codes
    for (int t = 0; t < 10; t++) begin
      for (int o = 0; o < 10; o++) begin
        v = {4'(t), 4'(o)};
        conv2(v, t * 10 + o, 0);
      end
    end

    // Three-digit spot checks
    conv3(12'h999, 999, 0);
    conv3(12'h000, 0, 0);
    conv3(12'h507, 507, 0);
    conv3(12'h9A9, 0, 1);
    conv3(12'h128, 128, 0);

    repeat (4) @(posedge clk);
    check("d2_queue_empty", q2.size(), 0);
    check("d3_queue_empty", q3.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got %0d compared, expected completion", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
